adder_share_ctrl: RTL and testbench

Round-robin controller that shares one external adder8bit instance between two requesters. It latches the winning requester's operands, drives them to the adder, and captures the (WIDTH+1)-bit sum into a result register. It presents the result with a valid/ready handshake tagged with the requester ID. It sits between the requesting logic and the single combinational adder in the FPGA_02 datapath.

---
 rtl/adder_share_ctrl.sv | 109 ++++++++++
 tb/tb_adder_share_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_ctrl.sv
// Round-robin arbiter that shares one combinational adder between two requesters.
// Latches the winner's operands, captures the WIDTH+1 bit sum, and returns it via valid/ready.
module adder_share_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             gnt0,
   output logic             gnt1,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   input  logic [WIDTH:0]   add_res,
   output logic             res_valid,
   output logic             res_id,
   output logic [WIDTH:0]   res,
   input  logic             res_ready,
   output logic             busy
);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e           state_q;
   logic             rr_ptr_q;
   logic             gnt0_q;
   logic             gnt1_q;
   logic [WIDTH-1:0] add_a_q;
   logic [WIDTH-1:0] add_b_q;
   logic             res_valid_q;
   logic             res_id_q;
   logic [WIDTH:0]   res_q;
   logic             busy_q;
   logic             winner;

   // A lone request wins outright; on contention the round-robin pointer decides.
   always_comb begin
      winner = 1'b0;
      if (req0 && req1) begin
         winner = rr_ptr_q;
      end else begin
         winner = req1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         rr_ptr_q    <= 1'b0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         add_a_q     <= '0;
         add_b_q     <= '0;
         res_valid_q <= 1'b0;
         res_id_q    <= 1'b0;
         res_q       <= '0;
         busy_q      <= 1'b0;
      end else begin
         gnt0_q <= 1'b0;
         gnt1_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req0 || req1) begin
                  add_a_q  <= winner ? a1 : a0;
                  add_b_q  <= winner ? b1 : b0;
                  gnt0_q   <= ~winner;
                  gnt1_q   <= winner;
                  res_id_q <= winner;
                  rr_ptr_q <= ~winner;
                  state_q  <= StCalc;
                  busy_q   <= 1'b1;
               end
            end
            StCalc: begin
               res_q       <= add_res;
               res_valid_q <= 1'b1;
               state_q     <= StDone;
            end
            StDone: begin
               // res and res_id stay put after the handshake; only valid drops.
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  state_q     <= StIdle;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               res_valid_q <= 1'b0;
               state_q     <= StIdle;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign add_a     = add_a_q;
   assign add_b     = add_b_q;
   assign res_valid = res_valid_q;
   assign res_id    = res_id_q;
   assign res       = res_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Scoreboard bench for adder_share_ctrl: directed requests push expected {id,sum}
// entries; a negedge monitor pops and compares on every accepted result.
module tb_adder_share_ctrl;

   localparam int unsigned WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             req0;
   logic [WIDTH-1:0] a0;
   logic [WIDTH-1:0] b0;
   logic             req1;
   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] b1;
   logic             gnt0;
   logic             gnt1;
   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic [WIDTH:0]   add_res;
   logic             res_valid;
   logic             res_id;
   logic [WIDTH:0]   res;
   logic             res_ready;
   logic             busy;

   int n_checks = 0;
   int n_fails  = 0;
   logic [WIDTH+1:0] sb[$];

   adder_share_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0      (req0),
      .a0        (a0),
      .b0        (b0),
      .req1      (req1),
      .a1        (a1),
      .b1        (b1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_res   (add_res),
      .res_valid (res_valid),
      .res_id    (res_id),
      .res       (res),
      .res_ready (res_ready),
      .busy      (busy)
   );

   // The shared combinational adder.
   assign add_res = {1'b0, add_a} + {1'b0, add_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fails++;
      $display("FAIL %s: timed out (t=%0t)", name, $time);
   endtask

   // Monitor: a result is consumed on the edge after a negedge that sees valid && ready.
   always @(negedge clk) begin
      if (rst_n && res_valid && res_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_res_valid", 32'(res_valid), 32'd0);
         end else begin
            logic [WIDTH+1:0] e;
            e = sb.pop_front();
            check("res_id", 32'(res_id), 32'(e[WIDTH+1]));
            check("res", 32'(res), 32'(e[WIDTH:0]));
         end
      end
   end

   // Raise one request, wait for its grant, check the latched operands and the pulse width.
   task automatic issue(input bit id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH:0] exp_sum, input bit push);
      bit seen;
      if (push) sb.push_back({id, exp_sum});
      @(posedge clk); #1;
      if (id) begin req1 = 1'b1; a1 = a; b1 = b; end
      else    begin req0 = 1'b1; a0 = a; b0 = b; end
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if ((id ? gnt1 : gnt0) === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
         timeout("gnt_wait");
         req0 = 1'b0;
         req1 = 1'b0;
         return;
      end
      check("add_a", 32'(add_a), 32'(a));
      check("add_b", 32'(add_b), 32'(b));
      check("busy_calc", 32'(busy), 32'd1);
      @(posedge clk); #1;
      if (id) req1 = 1'b0; else req0 = 1'b0;
      @(negedge clk);
      check("gnt_pulse_width", 32'(id ? gnt1 : gnt0), 32'd0);
      check("res_valid_done", 32'(res_valid), 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) timeout("scoreboard_drain");
   endtask

   initial begin
      bit exp_order [4];
      int g;
      bit seen;

      rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0; res_ready = 1'b1;
      #3;
      check("rst_gnt0", 32'(gnt0), 32'd0);
      check("rst_gnt1", 32'(gnt1), 32'd0);
      check("rst_add_a", 32'(add_a), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_res", 32'(res), 32'd0);
      #14 rst_n = 1'b1;

      // Single request: 100 + 77 = 177.
      issue(1'b0, 8'd100, 8'd77, 9'd177, 1'b1);
      @(negedge clk);
      check("res_valid_one_cycle", 32'(res_valid), 32'd0);
      drain();

      // Overflow: 255 + 255 = 510, carry in res[8].
      issue(1'b1, 8'd255, 8'd255, 9'd510, 1'b1);
      check("res_carry", 32'(res[WIDTH]), 32'd1);
      drain();

      // Contention: rr_ptr is back at 0, so grants alternate 0,1,0,1.
      exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;
      sb.push_back({1'b0, 9'd105});
      sb.push_back({1'b1, 9'd300});
      sb.push_back({1'b0, 9'd105});
      sb.push_back({1'b1, 9'd300});
      @(posedge clk); #1;
      req0 = 1'b1; a0 = 8'd70;  b0 = 8'd35;
      req1 = 1'b1; a1 = 8'd200; b1 = 8'd100;
      g = 0;
      for (int i = 0; i < 40 && g < 4; i++) begin
         @(negedge clk);
         if (gnt0 || gnt1) begin
            check("gnt_one_hot", 32'(gnt0 & gnt1), 32'd0);
            check("gnt_order", 32'(gnt1), 32'(exp_order[g]));
            g++;
         end
      end
      if (g < 4) timeout("rr_grants");
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
      drain();

      // Backpressure: hold result 5 cycles with req1 pending.
      @(posedge clk); #1;
      res_ready = 1'b0;
      issue(1'b0, 8'd10, 8'd20, 9'd30, 1'b1);
      @(posedge clk); #1;
      sb.push_back({1'b1, 9'd3});
      req1 = 1'b1; a1 = 8'd1; b1 = 8'd2;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_res_valid", 32'(res_valid), 32'd1);
         check("bp_res", 32'(res), 32'd30);
         check("bp_res_id", 32'(res_id), 32'd0);
         check("bp_no_gnt1", 32'(gnt1), 32'd0);
      end
      @(posedge clk); #1;
      res_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_gnt1_after_hs", 32'(gnt1), 32'd0);
      check("bp_valid_dropped", 32'(res_valid), 32'd0);
      check("bp_res_kept", 32'(res), 32'd30);
      @(negedge clk);
      check("bp_gnt1_granted", 32'(gnt1), 32'd1);
      @(posedge clk); #1;
      req1 = 1'b0;
      drain();

      // Reset mid-CALC: in-flight result (11) is dropped.
      seen = 1'b0;
      @(posedge clk); #1;
      req0 = 1'b1; a0 = 8'd5; b0 = 8'd6;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (gnt0) seen = 1'b1;
      end
      if (!seen) timeout("rst_gnt_wait");
      #2;
      req0 = 1'b0;
      rst_n = 1'b0;
      #1;
      check("mid_rst_gnt0", 32'(gnt0), 32'd0);
      check("mid_rst_add_a", 32'(add_a), 32'd0);
      check("mid_rst_add_b", 32'(add_b), 32'd0);
      check("mid_rst_res", 32'(res), 32'd0);
      check("mid_rst_res_id", 32'(res_id), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      #10 rst_n = 1'b1;

      // Idle: no request for 10 cycles.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_busy", 32'(busy), 32'd0);
         check("idle_gnt", 32'(gnt0 | gnt1), 32'd0);
         check("idle_res_valid", 32'(res_valid), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
